tohost_monitor: RTL and testbench
=================================

Name: tohost_monitor

Overview:
- Synthesizable pass/fail monitor that sits directly downstream of the RV32I core.
- Snoops the core's data-memory write port and retire PC.
- Decodes riscv-tests `tohost` writes into PASS/FAIL/TIMEOUT/HANG status.
- The simulation top uses it to end runs early and report the failing test number, instead of running a fixed tick count.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the `tohost` word; compare on addr[31:2].
- TIMEOUT, 5000, cycles in RUN before TIMEOUT is declared; must be ≥2.
- LOOP_LIMIT, 16, consecutive retires at an identical PC that declare HANG; must be ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mem_we  in  1  data-memory write strobe from core
- mem_addr  in  32  data-memory byte address
- mem_wdata  in  32  data-memory write data
- mem_wstrb  in  4  byte enables
- ret_valid  in  1  an instruction retires this cycle
- ret_pc  in  32  PC of the retiring instruction
- done  out  1  terminal state reached (sticky)
- pass  out  1  test passed (sticky, implies done)
- status  out  3  state encoding: RUN=0, PASS=1, FAIL=2, TIMEOUT=3, HANG=4
- fail_code  out  31  tohost[31:1] on FAIL, else 0
- cycles  out  32  cycles spent in RUN

Behaviour:
- Reset (rst=1 at posedge):
  - status=RUN; done=0, pass=0, fail_code=0, cycles=0.
  - Loop counter=0; last_pc valid flag=0.
  - Reset mid-run or in any terminal state returns to RUN with these values.
- Qualifying write: mem_we & (mem_addr[31:2]==TOHOST_ADDR[31:2]) & mem_wstrb==4'hF.
  - Partial-strobe writes to tohost are ignored.
- Decode of a qualifying write in RUN:
  - wdata==1 → PASS.
  - wdata[0]==1 and wdata!=1 → FAIL, with fail_code=wdata[31:1].
  - wdata[0]==0 (including 0) → ignored; syscall/marker values keep RUN.
- Cycle counter:
  - Increments by 1 every cycle in RUN, including the cycle of a transition out of RUN.
  - Frozen in terminal states.
  - Never wraps, since TIMEOUT < 2^32.
- Timeout: in RUN with cycles==TIMEOUT-1 and no other transition that cycle → TIMEOUT next cycle.
- Hang detection:
  - On ret_valid with last_pc valid and ret_pc==last_pc: loop_cnt+1.
  - On ret_valid with any other PC: loop_cnt=1.
  - last_pc<=ret_pc and last_pc valid flag set on every ret_valid.
  - When a retire would make loop_cnt==LOOP_LIMIT → HANG next cycle.
  - Cycles without ret_valid leave loop_cnt and last_pc unchanged.
- Priority for same-cycle events: PASS/FAIL write > HANG > TIMEOUT.
  - A pass write on the last timeout cycle yields PASS.
  - riscv-tests pass loops (`j .` after the tohost write) must therefore resolve to PASS, not HANG.
- Latency: status, done, pass and fail_code are registered and update on the clock edge that samples the event (visible one cycle after the event).
- Terminal states are absorbing until rst; later writes and retires are ignored.
- done = (status != RUN); pass = (status == PASS); both driven from registers, no combinational path from inputs.

Decomposition:
- Shared package (core defs header): status encoding constants, TOHOST_ADDR default, TIMEOUT default.
- One natural sub-module: pc_loop_detector (last_pc, valid flag, loop_cnt, hang pulse).
- Main FSM, decode and cycle counter stay in tohost_monitor.

Test Plan:
- Reset, then 10 idle cycles, then qualifying write wdata=1 → next cycle status=1, done=1, pass=1, cycles=11, fail_code=0.
- Write wdata=32'h0000_0007 → status=2, fail_code=3, pass=0; a later write of 1 leaves FAIL.
- Writes of wdata=0 and wdata=2, plus a wstrb=4'h3 write of 1, all to tohost → status stays 0. A write of 1 to TOHOST_ADDR+4 → status stays 0.
- TIMEOUT=20, no writes → status=3 after exactly 20 cycles, cycles=20. With a pass write on cycle 19 instead → status=1.
- ret_valid with ret_pc=32'h100 for 16 consecutive retires (LOOP_LIMIT=16), interleaved with idle cycles → HANG one cycle after the 16th. A pass write on the 16th retire cycle → PASS.
- Assert rst mid-run at cycles=50 and in PASS → all outputs return to reset values. A subsequent write of 0x9 → status=2, fail_code=4.

Source files
------------

// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost pass/fail monitor.
// Status encoding and default parameter values.
package tohost_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } status_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam int          TIMEOUT_DEF     = 5000;
  localparam int          LOOP_LIMIT_DEF  = 16;

  function automatic logic is_tohost(
    input logic [29:0] word,
    input logic [29:0] base
  );
    return word == base;
  endfunction

endpackage

// File: rtl/tohost_monitor_if.sv
// Snoop bundle: core data-memory write port plus retire info.
// The core side drives it; the monitor only listens.
interface tohost_monitor_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        ret_valid;
  logic [31:0] ret_pc;

  modport master (
    output mem_we, mem_addr, mem_wdata, mem_wstrb,
    output ret_valid, ret_pc
  );

  modport slave (
    input mem_we, mem_addr, mem_wdata, mem_wstrb,
    input ret_valid, ret_pc
  );
endinterface

// File: rtl/tohost_monitor_pc_loop_detector.sv
// Counts consecutive retires at one PC and flags a hang
// on the retire that would reach LOOP_LIMIT.
module pc_loop_detector #(
  parameter int LOOP_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  output logic        hang
);

  localparam int CW = $clog2(LOOP_LIMIT + 1);

  logic [31:0]   last_pc;
  logic          last_ok;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          take;

  assign take = en && ret_valid;

  always_comb begin
    cnt_d = CW'(1);
    if (last_ok && ret_pc == last_pc)
      cnt_d = cnt_q + CW'(1);
  end

  assign hang = take && (cnt_d == CW'(LOOP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc <= '0;
      last_ok <= 1'b0;
      cnt_q   <= '0;
    end else if (take) begin
      last_pc <= ret_pc;
      last_ok <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Decodes riscv-tests tohost writes, timeout and PC hang
// into a sticky terminal status for the simulation top.
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
  parameter int          TIMEOUT     = TIMEOUT_DEF,
  parameter int          LOOP_LIMIT  = LOOP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  tohost_monitor_if.slave   bus,
  output logic              done,
  output logic              pass,
  output logic [2:0]        status,
  output logic [30:0]       fail_code,
  output logic [31:0]       cycles
);

  status_e     state_q, state_d;
  logic [30:0] fail_q, fail_d;
  logic [31:0] cyc_q, cyc_d;

  logic wr, wr_pass, wr_fail, hang, last_cyc;
  logic unused_addr;

  assign unused_addr = &{1'b0, bus.mem_addr[1:0]};

  assign wr = bus.mem_we
           && is_tohost(bus.mem_addr[31:2], TOHOST_ADDR[31:2])
           && bus.mem_wstrb == 4'hF;

  assign wr_pass  = wr && bus.mem_wdata == 32'd1;
  assign wr_fail  = wr && bus.mem_wdata[0]
                       && bus.mem_wdata != 32'd1;
  assign last_cyc = cyc_q == 32'(TIMEOUT - 1);

  pc_loop_detector #(
    .LOOP_LIMIT (LOOP_LIMIT)
  ) u_loop (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_RUN),
    .ret_valid (bus.ret_valid),
    .ret_pc    (bus.ret_pc),
    .hang      (hang)
  );

  // Ordering of the arms sets event priority.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    cyc_d   = cyc_q;
    if (state_q == ST_RUN) begin
      cyc_d = cyc_q + 32'd1;
      priority case (1'b1)
        wr_pass:  state_d = ST_PASS;
        wr_fail: begin
          state_d = ST_FAIL;
          fail_d  = bus.mem_wdata[31:1];
        end
        hang:     state_d = ST_HANG;
        last_cyc: state_d = ST_TIMEOUT;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fail_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      cyc_q   <= cyc_d;
    end
  end

  assign status    = state_q;
  assign done      = state_q != ST_RUN;
  assign pass      = state_q == ST_PASS;
  assign fail_code = fail_q;
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed checks for tohost_monitor: decode, timeout,
// hang detection, priority and reset.
module tb_tohost_monitor;

  localparam logic [31:0] TH  = 32'h0000_1000;
  localparam int          TO  = 64;
  localparam int          LL  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        done, pass;
  logic [2:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycles;

  int n_chk = 0;
  int n_err = 0;

  tohost_monitor_if bus ();

  tohost_monitor #(
    .TOHOST_ADDR (TH),
    .TIMEOUT     (TO),
    .LOOP_LIMIT  (LL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .done      (done),
    .pass      (pass),
    .status    (status),
    .fail_code (fail_code),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.ret_valid = 1'b0;
    bus.ret_pc    = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    bus.mem_we    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    tick();
    idle_bus();
  endtask

  task automatic retire(input logic [31:0] pc);
    bus.ret_valid = 1'b1;
    bus.ret_pc    = pc;
    tick();
    idle_bus();
  endtask

  task automatic check_rst(input string tag);
    check({tag, ".status"}, 32'(status), 32'd0);
    check({tag, ".done"},   32'(done),   32'd0);
    check({tag, ".pass"},   32'(pass),   32'd0);
    check({tag, ".fail"},   32'(fail_code), 32'd0);
    check({tag, ".cycles"}, cycles,      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_bus();

    // pass after 10 idle cycles
    do_reset();
    check_rst("rst0");
    idle(10);
    wr(TH, 32'd1, 4'hF);
    check("p.status", 32'(status), 32'd1);
    check("p.done",   32'(done),   32'd1);
    check("p.pass",   32'(pass),   32'd1);
    check("p.cycles", cycles,      32'd11);
    check("p.fail",   32'(fail_code), 32'd0);
    idle(3);
    check("p.frozen", cycles,      32'd11);

    // fail code, sticky against later pass
    do_reset();
    wr(TH, 32'h0000_0007, 4'hF);
    check("f.status", 32'(status), 32'd2);
    check("f.code",   32'(fail_code), 32'd3);
    check("f.pass",   32'(pass),   32'd0);
    check("f.done",   32'(done),   32'd1);
    wr(TH, 32'd1, 4'hF);
    check("f.sticky", 32'(status), 32'd2);
    check("f.code2",  32'(fail_code), 32'd3);

    // ignored writes
    do_reset();
    wr(TH, 32'd0, 4'hF);
    check("i.zero",   32'(status), 32'd0);
    wr(TH, 32'd2, 4'hF);
    check("i.even",   32'(status), 32'd0);
    wr(TH, 32'd1, 4'h3);
    check("i.strb",   32'(status), 32'd0);
    wr(TH + 32'd4, 32'd1, 4'hF);
    check("i.addr",   32'(status), 32'd0);
    check("i.cycles", cycles,      32'd4);
    wr(TH + 32'd2, 32'd1, 4'hF);
    check("i.lowbit", 32'(status), 32'd1);

    // timeout
    do_reset();
    idle(TO - 1);
    check("t.pre",    32'(status), 32'd0);
    check("t.precyc", cycles,      32'(TO - 1));
    idle(1);
    check("t.status", 32'(status), 32'd3);
    check("t.cycles", cycles,      32'(TO));
    check("t.done",   32'(done),   32'd1);
    idle(2);
    check("t.frozen", cycles,      32'(TO));

    // pass on last timeout cycle wins
    do_reset();
    idle(TO - 1);
    wr(TH, 32'd1, 4'hF);
    check("tp.status", 32'(status), 32'd1);
    check("tp.cycles", cycles,      32'(TO));

    // hang with interleaved idles
    do_reset();
    retire(32'h104);
    retire(32'h100);
    idle(1);
    retire(32'h104);
    for (int i = 0; i < LL - 1; i++) begin
      retire(32'h100);
      idle(1);
    end
    check("h.pre",    32'(status), 32'd0);
    retire(32'h100);
    check("h.status", 32'(status), 32'd4);
    check("h.done",   32'(done),   32'd1);
    check("h.pass",   32'(pass),   32'd0);

    // pass write on the hang-completing retire
    do_reset();
    for (int i = 0; i < LL - 1; i++) begin
      retire(32'h100);
      idle(1);
    end
    bus.ret_valid = 1'b1;
    bus.ret_pc    = 32'h100;
    wr(TH, 32'd1, 4'hF);
    check("hp.status", 32'(status), 32'd1);
    check("hp.pass",   32'(pass),   32'd1);

    // reset mid-run, reset in PASS, then fail
    do_reset();
    idle(50);
    check("r.cyc50",  cycles,      32'd50);
    do_reset();
    check_rst("rst1");
    wr(TH, 32'd1, 4'hF);
    check("r.pass",   32'(status), 32'd1);
    do_reset();
    check_rst("rst2");
    wr(TH, 32'h9, 4'hF);
    check("r.status", 32'(status), 32'd2);
    check("r.code",   32'(fail_code), 32'd4);
    check("r.cycles", cycles,      32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
